// File: rtl/llc_mem_adapter_pkg.sv
// Shared types for the LLC memory adapter: line geometry,
// request attribute types and the adapter FSM state encoding.
package llc_mem_adapter_pkg;

  localparam int BITS_PER_LINE    = 128;
  localparam int WORD_OFFSET_BITS = 1;

  typedef logic [1:0]  hprot_t;
  typedef logic [2:0]  hsize_t;
  typedef logic [27:0] line_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    WACK,
    RDATA,
    RSP
  } mem_adapter_state_t;

endpackage

// File: rtl/llc_mem_line_shifter.sv
// Line buffer with beat-indexed read/write and the beat counter
// shared by the write serializer and the read collector.
module llc_mem_line_shifter #(
  parameter int  LINE_BITS = 128,
  parameter int  BEAT_BITS = 64,
  localparam int CNT_W     = $clog2(LINE_BITS / BEAT_BITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LINE_BITS-1:0] line_i,
  input  logic                 wr_i,
  input  logic [BEAT_BITS-1:0] beat_i,
  input  logic                 adv_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic [BEAT_BITS-1:0] beat_o,
  output logic [CNT_W-1:0]     cnt_o
);

  localparam int IDX_W = $clog2(LINE_BITS);
  localparam int BSH   = $clog2(BEAT_BITS);

  logic [LINE_BITS-1:0] line_q, line_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     base;

  // Beat offset is cnt scaled by the beat width.
  assign base = {cnt_q, {BSH{1'b0}}};

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      line_d = line_i;
      cnt_d  = '0;
    end else if (wr_i) begin
      line_d[base +: BEAT_BITS] = beat_i;
      cnt_d = cnt_q + 1'b1;
    end else if (adv_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[base +: BEAT_BITS];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/llc_mem_adapter.sv
// LLC line <-> narrow burst memory adapter, one transaction at a time.
// LLC_MEM_WR_ACK_EN adds the write-acknowledge channel and WACK state.
module llc_mem_adapter
  import llc_mem_adapter_pkg::*;
#(
  parameter int LINE_BITS   = BITS_PER_LINE,
  parameter int BEAT_BITS   = 64,
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_hwrite,
  input  logic [2:0]                    req_hsize,
  input  logic [1:0]                    req_hprot,
  input  logic [ADDR_BITS-OFFSET_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0]          req_line,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [LINE_BITS-1:0]          rsp_line,
  output logic                          mem_cmd_valid,
  input  logic                          mem_cmd_ready,
  output logic                          mem_cmd_write,
  output logic [ADDR_BITS-1:0]          mem_cmd_addr,
  output logic [7:0]                    mem_cmd_len,
  output logic [1:0]                    mem_cmd_hprot,
  output logic                          mem_wdata_valid,
  input  logic                          mem_wdata_ready,
  output logic [BEAT_BITS-1:0]          mem_wdata,
  output logic                          mem_wdata_last,
  input  logic                          mem_rdata_valid,
  output logic                          mem_rdata_ready,
  input  logic [BEAT_BITS-1:0]          mem_rdata,
  input  logic                          mem_rdata_last,
`ifdef LLC_MEM_WR_ACK_EN
  input  logic                          mem_wack_valid,
  output logic                          mem_wack_ready,
`endif
  output logic                          busy,
  output logic                          protocol_err
);

  localparam int LA_W  = ADDR_BITS - OFFSET_BITS;
  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
`ifdef LLC_MEM_WR_ACK_EN
  localparam mem_adapter_state_t WR_DONE = WACK;
`else
  localparam mem_adapter_state_t WR_DONE = IDLE;
`endif

  mem_adapter_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       hwrite_q;
  hprot_t     hprot_q;
  logic [LA_W-1:0] addr_q;
  logic       req_ready_q, cmd_valid_q, wdata_valid_q;
  logic       rdata_ready_q, rsp_valid_q, busy_q, wack_ready_q;
  logic       req_fire, cmd_fire, wd_fire, rd_fire, rsp_fire, wack_fire;
  logic       last_beat;
  logic [CNT_W-1:0]     cnt;
  logic [LINE_BITS-1:0] line;
  logic [BEAT_BITS-1:0] beat;
  hsize_t     hsize_unused;

  assign hsize_unused = req_hsize;

  assign req_fire  = req_ready_q & req_valid;
  assign cmd_fire  = cmd_valid_q & mem_cmd_ready;
  assign wd_fire   = wdata_valid_q & mem_wdata_ready;
  assign rd_fire   = rdata_ready_q & mem_rdata_valid;
  assign rsp_fire  = rsp_valid_q & rsp_ready;
  assign last_beat = (cnt == LAST_CNT);
`ifdef LLC_MEM_WR_ACK_EN
  assign wack_fire = wack_ready_q & mem_wack_valid;
`else
  assign wack_fire = 1'b0;
`endif

  llc_mem_line_shifter #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load_i (req_fire),
    .line_i (req_line),
    .wr_i   (rd_fire),
    .beat_i (mem_rdata),
    .adv_i  (wd_fire),
    .line_o (line),
    .beat_o (beat),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:  if (req_fire) state_d = CMD;
      CMD:   if (cmd_fire) state_d = hwrite_q ? WDATA : RDATA;
      WDATA: if (wd_fire && last_beat) state_d = WR_DONE;
      WACK:  if (wack_fire || WR_DONE == IDLE) state_d = IDLE;
      RDATA: begin
        // Framing check only; completion follows the local count.
        if (rd_fire) begin
          if (mem_rdata_last != last_beat) err_d = 1'b1;
          if (last_beat) state_d = RSP;
        end
      end
      RSP:   if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      err_q         <= 1'b0;
      hwrite_q      <= 1'b0;
      hprot_q       <= '0;
      addr_q        <= '0;
      req_ready_q   <= 1'b1;
      cmd_valid_q   <= 1'b0;
      wdata_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      wack_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      req_ready_q   <= (state_d == IDLE);
      cmd_valid_q   <= (state_d == CMD);
      wdata_valid_q <= (state_d == WDATA);
      rdata_ready_q <= (state_d == RDATA);
      rsp_valid_q   <= (state_d == RSP);
      wack_ready_q  <= (state_d == WACK);
      busy_q        <= (state_d != IDLE);
      if (req_fire) begin
        hwrite_q <= req_hwrite;
        hprot_q  <= req_hprot;
        addr_q   <= req_addr;
      end
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_line        = line;
  assign mem_cmd_valid   = cmd_valid_q;
  assign mem_cmd_write   = hwrite_q;
  assign mem_cmd_addr    = {addr_q, {OFFSET_BITS{1'b0}}};
  assign mem_cmd_len     = cmd_valid_q ? 8'(BEATS - 1) : 8'd0;
  assign mem_cmd_hprot   = hprot_q;
  assign mem_wdata_valid = wdata_valid_q;
  assign mem_wdata       = beat;
  assign mem_wdata_last  = wdata_valid_q & last_beat;
  assign mem_rdata_ready = rdata_ready_q;
  assign busy            = busy_q;
  assign protocol_err    = err_q;
`ifdef LLC_MEM_WR_ACK_EN
  assign mem_wack_ready  = wack_ready_q;
`else
  logic wack_unused;
  assign wack_unused = wack_ready_q | wack_fire;
`endif

endmodule

// File: tb/tb_llc_mem_adapter.sv
// Directed self-checking bench for llc_mem_adapter (default geometry,
// two beats per line); follows LLC_MEM_WR_ACK_EN when defined.
module tb_llc_mem_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 0, req_ready, req_hwrite = 0;
  logic [2:0]   req_hsize = 3'd4;
  logic [1:0]   req_hprot = 0;
  logic [27:0]  req_addr = 0;
  logic [127:0] req_line = 0;
  logic         rsp_valid, rsp_ready = 0;
  logic [127:0] rsp_line;
  logic         mem_cmd_valid, mem_cmd_ready = 0, mem_cmd_write;
  logic [31:0]  mem_cmd_addr;
  logic [7:0]   mem_cmd_len;
  logic [1:0]   mem_cmd_hprot;
  logic         mem_wdata_valid, mem_wdata_ready = 0, mem_wdata_last;
  logic [63:0]  mem_wdata;
  logic         mem_rdata_valid = 0, mem_rdata_ready, mem_rdata_last = 0;
  logic [63:0]  mem_rdata = 0;
  logic         busy, protocol_err;
`ifdef LLC_MEM_WR_ACK_EN
  logic         mem_wack_valid = 0, mem_wack_ready;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  llc_mem_adapter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_hwrite      (req_hwrite),
    .req_hsize       (req_hsize),
    .req_hprot       (req_hprot),
    .req_addr        (req_addr),
    .req_line        (req_line),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_line        (rsp_line),
    .mem_cmd_valid   (mem_cmd_valid),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_cmd_write   (mem_cmd_write),
    .mem_cmd_addr    (mem_cmd_addr),
    .mem_cmd_len     (mem_cmd_len),
    .mem_cmd_hprot   (mem_cmd_hprot),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_wdata       (mem_wdata),
    .mem_wdata_last  (mem_wdata_last),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_last  (mem_rdata_last),
`ifdef LLC_MEM_WR_ACK_EN
    .mem_wack_valid  (mem_wack_valid),
    .mem_wack_ready  (mem_wack_ready),
`endif
    .busy            (busy),
    .protocol_err    (protocol_err)
  );

  // Drives one fill; reports what it saw, checks are left to the caller.
  task automatic run_read(input logic [27:0] a, input logic [63:0] b0,
                          input logic [63:0] b1, input logic bad_last,
                          input int hold,
                          output logic [127:0] first_line,
                          output logic [127:0] final_line,
                          output int lat, output int rsp_cycles,
                          output logic timeout);
    int ridx = 0;
    int c = 0;
    int held = 0;
    logic done = 0;
    timeout = 1; lat = -1; rsp_cycles = 0;
    first_line = '0; final_line = '0;
    @(negedge clk);
    req_valid = 1; req_hwrite = 0; req_addr = a;
    rsp_ready = 0; mem_cmd_ready = 1;
    while (c < 50 && !done) begin
      @(negedge clk);
      c++;
      req_valid = 0;
      if (rsp_valid) begin
        if (rsp_cycles == 0) begin
          lat = c; first_line = rsp_line;
        end
        rsp_cycles++;
        if (held < hold) begin
          held++; rsp_ready = 0;
        end else begin
          rsp_ready = 1; final_line = rsp_line;
          done = 1; timeout = 0;
        end
      end
      if (ridx < 2) begin
        mem_rdata_valid = 1;
        mem_rdata = (ridx == 0) ? b0 : b1;
        mem_rdata_last = (ridx == 1) || bad_last;
        if (mem_rdata_ready) ridx++;
      end else begin
        mem_rdata_valid = 0; mem_rdata_last = 0;
      end
    end
    @(negedge clk);
    rsp_ready = 0; mem_rdata_valid = 0; mem_rdata_last = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1 rst = 0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %0b want 1", req_ready);
    end
    total++;
    if ({busy, protocol_err} !== 2'b00) begin
      bad++; $display("FAIL reset_busy_err: got %b want 00", {busy, protocol_err});
    end
    total++;
    if ({mem_cmd_valid, mem_wdata_valid, mem_rdata_ready, rsp_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_valids: got %b want 0000",
        {mem_cmd_valid, mem_wdata_valid, mem_rdata_ready, rsp_valid});
    end
    total++;
    if ({mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_hprot} !== 43'd0) begin
      bad++; $display("FAIL reset_cmd: got addr %h len %0d want 0", mem_cmd_addr, mem_cmd_len);
    end
    total++;
    if (rsp_line !== 128'd0) begin
      bad++; $display("FAIL reset_rsp_line: got %h want 0", rsp_line);
    end
`ifdef LLC_MEM_WR_ACK_EN
    total++;
    if (mem_wack_ready !== 1'b0) begin
      bad++; $display("FAIL reset_wack_ready: got %b want 0", mem_wack_ready);
    end
`endif
    rst = 1;
  endtask

  task automatic test_read();
    logic [63:0] b0 = 64'h1111_1111_1111_1111;
    logic [63:0] b1 = 64'h2222_2222_2222_2222;
    @(negedge clk);
    req_valid = 1; req_hwrite = 0; req_addr = 28'h0ABC; req_hprot = 2'b10;
    mem_cmd_ready = 1; rsp_ready = 1;
    @(negedge clk);
    total++;
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_hprot, req_ready}
        !== {1'b1, 1'b0, 32'h0000_ABC0, 8'd1, 2'b10, 1'b0}) begin
      bad++; $display("FAIL read_cmd: got v%b w%b a%h l%0d p%0d want v1 w0 a0000abc0 l1 p2",
        mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_hprot);
    end
    req_valid = 0; mem_rdata_valid = 1; mem_rdata = b0; mem_rdata_last = 0;
    @(negedge clk);
    total++;
    if ({mem_rdata_ready, mem_cmd_valid} !== 2'b10) begin
      bad++; $display("FAIL read_rdata_ready: got %b want 10", {mem_rdata_ready, mem_cmd_valid});
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL read_rsp_early: got %b want 0", rsp_valid);
    end
    mem_rdata = b1; mem_rdata_last = 1;
    @(negedge clk);
    mem_rdata_valid = 0; mem_rdata_last = 0;
    total++;
    if ({rsp_valid, mem_rdata_ready, rsp_line} !== {1'b1, 1'b0, b1, b0}) begin
      bad++; $display("FAIL read_rsp: got v%b line %h want v1 line %h", rsp_valid, rsp_line, {b1, b0});
    end
    @(negedge clk);
    rsp_ready = 0;
    total++;
    if ({rsp_valid, req_ready, busy, protocol_err} !== 4'b0100) begin
      bad++; $display("FAIL read_idle: got %b want 0100", {rsp_valid, req_ready, busy, protocol_err});
    end
  endtask

  task automatic test_write();
    logic [63:0] a = 64'hAAAA_AAAA_AAAA_AAAA;
    logic [63:0] b = 64'hBBBB_BBBB_BBBB_BBBB;
    logic no_rsp = 1;
    @(negedge clk);
    req_valid = 1; req_hwrite = 1; req_addr = 28'h0123; req_hprot = 2'b01;
    req_line = {b, a}; mem_cmd_ready = 1; mem_wdata_ready = 1;
`ifdef LLC_MEM_WR_ACK_EN
    mem_wack_valid = 1;
`endif
    @(negedge clk);
    req_valid = 0;
    no_rsp &= !rsp_valid;
    total++;
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len, mem_cmd_hprot}
        !== {1'b1, 1'b1, 32'h0000_1230, 8'd1, 2'b01}) begin
      bad++; $display("FAIL write_cmd: got v%b w%b a%h want v1 w1 a00001230",
        mem_cmd_valid, mem_cmd_write, mem_cmd_addr);
    end
    @(negedge clk);
    no_rsp &= !rsp_valid;
    total++;
    if ({mem_wdata_valid, mem_wdata, mem_wdata_last} !== {1'b1, a, 1'b0}) begin
      bad++; $display("FAIL write_beat0: got v%b d%h l%b want v1 d%h l0",
        mem_wdata_valid, mem_wdata, mem_wdata_last, a);
    end
`ifdef LLC_MEM_WR_ACK_EN
    total++;
    if (mem_wack_ready !== 1'b0) begin
      bad++; $display("FAIL write_early_wack: got %b want 0", mem_wack_ready);
    end
`endif
    @(negedge clk);
    no_rsp &= !rsp_valid;
    total++;
    if ({mem_wdata_valid, mem_wdata, mem_wdata_last} !== {1'b1, b, 1'b1}) begin
      bad++; $display("FAIL write_beat1: got v%b d%h l%b want v1 d%h l1",
        mem_wdata_valid, mem_wdata, mem_wdata_last, b);
    end
    @(negedge clk);
    no_rsp &= !rsp_valid;
`ifdef LLC_MEM_WR_ACK_EN
    total++;
    if ({busy, mem_wack_ready, mem_wdata_valid} !== 3'b110) begin
      bad++; $display("FAIL write_wack_state: got %b want 110", {busy, mem_wack_ready, mem_wdata_valid});
    end
    @(negedge clk);
    mem_wack_valid = 0;
    no_rsp &= !rsp_valid;
`endif
    total++;
    if ({busy, req_ready, mem_wdata_valid} !== 3'b010) begin
      bad++; $display("FAIL write_idle: got %b want 010", {busy, req_ready, mem_wdata_valid});
    end
    total++;
    if (no_rsp !== 1'b1) begin
      bad++; $display("FAIL write_no_rsp: got rsp_valid seen want none");
    end
    req_hwrite = 0;
  endtask

  task automatic test_backpressure();
    logic [63:0] ex [2];
    logic [127:0] fl, ll;
    int idx = 0;
    int lat, rc;
    logic tog = 0;
    logic to;
    ex[0] = 64'hC0C0_C0C0_C0C0_C0C0;
    ex[1] = 64'hD1D1_D1D1_D1D1_D1D1;
    @(negedge clk);
    req_valid = 1; req_hwrite = 1; req_addr = 28'h0777; req_line = {ex[1], ex[0]};
    mem_cmd_ready = 0; mem_wdata_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 0;
      total++;
      if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr} !== {1'b1, 1'b1, 32'h0000_7770}) begin
        bad++; $display("FAIL bp_cmd_hold%0d: got v%b a%h want v1 a00007770", i, mem_cmd_valid, mem_cmd_addr);
      end
    end
    @(negedge clk);
    mem_cmd_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_cmd_ready = 0;
      if (mem_wdata_valid) begin
        total++;
        if (idx > 1 || {mem_wdata, mem_wdata_last} !== {ex[idx[0]], idx == 1}) begin
          bad++; $display("FAIL bp_wbeat%0d: got d%h l%b want d%h l%b",
            idx, mem_wdata, mem_wdata_last, ex[idx[0]], idx == 1);
        end
        mem_wdata_ready = tog;
        if (tog) idx++;
        tog = !tog;
      end else if (idx == 2) begin
        break;
      end
    end
    mem_wdata_ready = 0;
    total++;
    if (idx !== 2) begin
      bad++; $display("FAIL bp_wbeat_count: got %0d want 2", idx);
    end
`ifdef LLC_MEM_WR_ACK_EN
    mem_wack_valid = 1;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    mem_wack_valid = 0;
`endif
    total++;
    if ({busy, req_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_write_idle: got %b want 01", {busy, req_ready});
    end
    req_hwrite = 0;
    run_read(28'h0055, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 2, fl, ll, lat, rc, to);
    total++;
    if (to || fl !== ll || ll !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333}) begin
      bad++; $display("FAIL bp_rsp_line: got first %h last %h to%b want 44..33..", fl, ll, to);
    end
    total++;
    if (lat !== 4 || rc !== 3) begin
      bad++; $display("FAIL bp_rsp_hold: got lat %0d cycles %0d want 4 3", lat, rc);
    end
  endtask

  task automatic test_protocol_err();
    logic [127:0] fl, ll;
    int lat, rc;
    logic to;
    total++;
    if (protocol_err !== 1'b0) begin
      bad++; $display("FAIL perr_pre: got %b want 0", protocol_err);
    end
    run_read(28'h0101, 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5, 1, 0, fl, ll, lat, rc, to);
    total++;
    if (protocol_err !== 1'b1) begin
      bad++; $display("FAIL perr_set: got %b want 1", protocol_err);
    end
    total++;
    if (to || lat !== 4 || ll !== {64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A}) begin
      bad++; $display("FAIL perr_rsp: got lat %0d line %h want 4 a5..5a..", lat, ll);
    end
    run_read(28'h0102, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 0, 0, fl, ll, lat, rc, to);
    total++;
    if (protocol_err !== 1'b1 || ll !== {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F}) begin
      bad++; $display("FAIL perr_sticky: got err %b line %h want 1 f0..0f..", protocol_err, ll);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] fl, ll;
    int lat, rc;
    logic to;
    @(negedge clk);
    req_valid = 1; req_hwrite = 0; req_addr = 28'h0BAD; mem_cmd_ready = 1;
    @(negedge clk);
    req_valid = 0; mem_rdata_valid = 1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    mem_rdata_last = 0;
    @(negedge clk);
    @(negedge clk);
    mem_rdata_valid = 0;
    total++;
    if ({mem_rdata_ready, busy} !== 2'b11) begin
      bad++; $display("FAIL rstmid_pre: got %b want 11", {mem_rdata_ready, busy});
    end
    #2 rst = 0;
    #1;
    total++;
    if ({req_ready, busy, protocol_err, mem_rdata_ready, rsp_valid, mem_cmd_valid}
        !== 6'b100000 || rsp_line !== 128'd0) begin
      bad++; $display("FAIL rstmid_async: got %b line %h want 100000 line 0",
        {req_ready, busy, protocol_err, mem_rdata_ready, rsp_valid, mem_cmd_valid}, rsp_line);
    end
    @(negedge clk);
    rst = 1;
    run_read(28'h0C0D, 64'h9999_9999_9999_9999, 64'h7777_7777_7777_7777, 0, 0, fl, ll, lat, rc, to);
    total++;
    if (to || lat !== 4 || ll !== {64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999}) begin
      bad++; $display("FAIL rstmid_recover: got lat %0d line %h want 4 77..99..", lat, ll);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bt [2][2];
    int acc [2];
    int rspc [2];
    logic [127:0] lines [2];
    int na = 0;
    int nr = 0;
    int ridx = 0;
    int c = 0;
    bt[0][0] = 64'h5555_5555_5555_5555; bt[0][1] = 64'h6666_6666_6666_6666;
    bt[1][0] = 64'h1234_1234_1234_1234; bt[1][1] = 64'h8888_8888_8888_8888;
    acc[0] = -1; acc[1] = -1; rspc[0] = -1; rspc[1] = -1;
    lines[0] = '0; lines[1] = '0;
    @(negedge clk);
    rsp_ready = 1; mem_cmd_ready = 1; req_hwrite = 0; req_addr = 28'h0200;
    req_valid = 1;
    if (req_ready) begin acc[na] = c; na++; end
    mem_rdata_valid = 1; mem_rdata = bt[0][0]; mem_rdata_last = 0;
    while (nr < 2 && c < 60) begin
      @(negedge clk);
      c++;
      if (rsp_valid) begin
        rspc[nr] = c; lines[nr] = rsp_line; nr++; ridx = 0;
        if (nr == 2) req_valid = 0;
      end
      if (req_valid && req_ready && na < 2) begin acc[na] = c; na++; end
      if (nr < 2 && ridx < 2) begin
        mem_rdata_valid = 1; mem_rdata = bt[nr][ridx]; mem_rdata_last = (ridx == 1);
        if (mem_rdata_ready) ridx++;
      end else begin
        mem_rdata_valid = 0; mem_rdata_last = 0;
      end
    end
    @(negedge clk);
    rsp_ready = 0;
    total++;
    if (na !== 2 || nr !== 2 || acc[0] !== 0 || rspc[0] !== 4) begin
      bad++; $display("FAIL b2b_first: got acc %0d rsp %0d n %0d/%0d want 0 4 2/2",
        acc[0], rspc[0], na, nr);
    end
    total++;
    if (acc[1] !== rspc[0] + 1 || rspc[1] !== 9) begin
      bad++; $display("FAIL b2b_second: got acc %0d rsp %0d want %0d 9", acc[1], rspc[1], rspc[0] + 1);
    end
    total++;
    if (lines[0] !== {bt[0][1], bt[0][0]} || lines[1] !== {bt[1][1], bt[1][0]}) begin
      bad++; $display("FAIL b2b_lines: got %h %h want %h %h",
        lines[0], lines[1], {bt[0][1], bt[0][0]}, {bt[1][1], bt[1][0]});
    end
    total++;
    if ({req_ready, busy} !== 2'b10) begin
      bad++; $display("FAIL b2b_idle: got %b want 10", {req_ready, busy});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_protocol_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/llc_mem_adapter.md
# llc_mem_adapter

Downstream stage of the LLC core. It consumes the core's single-line memory request (`llc_mem_req` channel), serializes each cache line into fixed-width beats on a narrow burst memory port, collects read beats back into a full line, and returns that line on the core's `llc_mem_rsp` channel. It handles one transaction at a time; the core already allows only one memory access in flight.

## Interface
Parameters:
- `LINE_BITS`, default 128: cache line width; must equal `BITS_PER_LINE` in the shared package.
- `BEAT_BITS`, default 64: memory data bus width. `LINE_BITS/BEAT_BITS` (`BEATS`) must be a power of 2 and ≥2.
- `ADDR_BITS`, default 32: byte address width.
- `OFFSET_BITS`, default 4: log2 of line bytes. The line address width is `ADDR_BITS-OFFSET_BITS`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1 / `req_ready` out 1: core request handshake.
- `req_hwrite` in 1: 1 = writeback, 0 = line fill.
- `req_hsize` in 3, `req_hprot` in 2: forwarded attributes.
- `req_addr` in `ADDR_BITS-OFFSET_BITS`: line address.
- `req_line` in `LINE_BITS`: write data.
- `rsp_valid` out 1 / `rsp_ready` in 1 / `rsp_line` out `LINE_BITS`: fill response to the core.
- `mem_cmd_valid` out 1 / `mem_cmd_ready` in 1: burst command handshake.
- `mem_cmd_write` out 1, `mem_cmd_addr` out `ADDR_BITS`, `mem_cmd_len` out 8 (value is `BEATS-1`), `mem_cmd_hprot` out 2.
- `mem_wdata_valid` out 1 / `mem_wdata_ready` in 1 / `mem_wdata` out `BEAT_BITS` / `mem_wdata_last` out 1.
- `mem_rdata_valid` in 1 / `mem_rdata_ready` out 1 / `mem_rdata` in `BEAT_BITS` / `mem_rdata_last` in 1.
- `mem_wack_valid` in 1 / `mem_wack_ready` out 1: present only with `LLC_MEM_WR_ACK_EN`.
- `busy` out 1: high in any state other than IDLE.
- `protocol_err` out 1: sticky error flag.

## Operation
States:
- IDLE: `req_ready=1`. On `req_valid`, register hwrite, hprot, address and line, clear the beat counter, then go to CMD.
- CMD: `mem_cmd_valid=1`, with the command fields driven from registers. `mem_cmd_addr={req_addr,OFFSET_BITS'b0}`. On `mem_cmd_ready`, go to WDATA if the request is a write, otherwise to RDATA.
- WDATA:
  - `mem_wdata = line[cnt*BEAT_BITS +: BEAT_BITS]`, lowest beat first.
  - `mem_wdata_last = (cnt==BEATS-1)`.
  - Each `valid&ready` increments `cnt`.
  - After the last beat, go to WACK if the macro is defined, otherwise to IDLE.
- WACK: `mem_wack_ready=1`; on `mem_wack_valid`, go to IDLE.
- RDATA:
  - `mem_rdata_ready=1`. Each accepted beat is written to `line[cnt*BEAT_BITS +: BEAT_BITS]` and increments `cnt`.
  - Set `protocol_err` if `mem_rdata_last` is high with `cnt!=BEATS-1`, or low with `cnt==BEATS-1`.
  - Completion is decided by `cnt` only; `last` is never used. Go to RSP after beat `BEATS-1`.
- RSP: `rsp_valid=1` and `rsp_line` = the assembled line; on `rsp_ready`, go to IDLE.
- Writes produce no core response.

Rules:
- `cnt` is `$clog2(BEATS)` bits wide and wraps to 0 naturally after the last beat.
- Every valid is held with stable payload until its ready. Valids are never combinationally dependent on readies.
- `mem_rdata_ready` is 0 outside RDATA. Beats arriving early are not consumed.
- `mem_wack_valid` outside WACK is ignored and not acknowledged.
- `protocol_err` is cleared only by reset.
- Reset mid-operation: return to IDLE immediately. Partial bursts are abandoned, so the memory model must also be reset.

## Timing
Reset values: `req_ready=1`; `busy=0` and `protocol_err=0`; every valid/ready output 0; `mem_cmd_*` 0; `rsp_line` 0.

Latency:
- Request accept to `mem_cmd_valid`: 1 cycle.
- Write with zero-wait memory: accept at cycle 0, command at 1, beats at 2..`BEATS+1`, IDLE at `BEATS+2` without the macro.
- Read with zero-wait memory and rdata valid in the cycle after the command: command at 1, beats at 2..`BEATS+1`, `rsp_valid` at `BEATS+2`.
- Back-to-back requests: the next `req_ready` comes one cycle after the previous transaction completes. No overlap.

## Configuration
- `LLC_MEM_WR_ACK_EN` defined: the WACK state and the `mem_wack_*` ports exist. A writeback completes only on the acknowledge, so `busy` stays high until then.
- Not defined: no ports and no state. A write completes on the last data beat.

## Structure
- Shared package:
  - `BITS_PER_LINE`, `WORD_OFFSET_BITS`.
  - `hprot_t`, `hsize_t`, `line_addr_t`.
  - A `mem_adapter_state_t` enum (IDLE, CMD, WDATA, WACK, RDATA, RSP).
- One natural sub-module, `llc_mem_line_shifter`: holds the line register with beat-indexed read/write and the beat counter. The FSM stays in the top.

## Test plan
1. Read, `BEATS=2`, addr `0x0ABC` → `mem_cmd_addr=0x0ABC0`, `len=1`, `write=0`. Beats `0x11..` then `0x22..` → `rsp_line={0x22..,0x11..}`, `rsp_valid` at cycle 4.
2. Write, line `{B,A}` → `mem_wdata` A then B, `last` only on B. No `rsp_valid`. IDLE at cycle 4, or after the wack when the macro is defined.
3. Backpressure: `mem_cmd_ready` low 3 cycles, `wdata_ready` toggling, `rsp_ready` low 2 cycles → payloads stable while waiting, no beat lost or duplicated.
4. `mem_rdata_last` asserted on beat 0 of 2 → `protocol_err=1` and stays 1. Response still issued after 2 beats.
5. Reset asserted during RDATA after 1 beat → outputs at reset values asynchronously. A new read completes correctly after reset.
6. Two back-to-back reads, `req_valid` held → the second `req_ready` comes exactly 1 cycle after the first `rsp_valid&rsp_ready`.
